// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// functs and every datapath select code.
package mc_pkg;

    // FSM state codes (also visible on the debug port)
    localparam logic [2:0] ST_IF  = 3'd0;
    localparam logic [2:0] ST_ID  = 3'd1;
    localparam logic [2:0] ST_EXE = 3'd2;
    localparam logic [2:0] ST_MEM = 3'd3;
    localparam logic [2:0] ST_WB  = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_OR     = 3'b010;
    localparam logic [2:0] ALU_SLT    = 3'b011;
    localparam logic [2:0] ALU_PASS_B = 3'b100;

    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_RS     = 2'b11;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    // Instruction classes: one per distinct path through the FSM
    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_RALU    = 4'd1,
        CLS_JR      = 4'd2,
        CLS_IALU    = 4'd3,
        CLS_LW      = 4'd4,
        CLS_SW      = 4'd5,
        CLS_BEQ     = 4'd6,
        CLS_J       = 4'd7,
        CLS_JAL     = 4'd8
    } instr_class_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: opcode/funct to instruction class,
// extender mode, ALU configuration and illegal flag.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t cls,
    output logic [1:0]   ext_op,
    output logic [2:0]   alu_op,
    output logic         alu_src_b,
    output logic         illegal
);

    // NOTE: every output gets a default before the case so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        cls       = CLS_ILLEGAL;
        ext_op    = EXT_SIGN;
        alu_op    = ALU_ADD;
        alu_src_b = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: begin cls = CLS_RALU; alu_op = ALU_ADD; end
                    FN_SUBU: begin cls = CLS_RALU; alu_op = ALU_SUB; end
                    FN_SLT:  begin cls = CLS_RALU; alu_op = ALU_SLT; end
                    FN_JR:   cls = CLS_JR;
                    default: cls = CLS_ILLEGAL;
                endcase
            end
            OP_ORI: begin
                cls       = CLS_IALU;
                ext_op    = EXT_ZERO;
                alu_op    = ALU_OR;
                alu_src_b = 1'b1;
            end
            OP_LUI: begin
                cls       = CLS_IALU;
                ext_op    = EXT_UPPER;
                alu_op    = ALU_PASS_B;
                alu_src_b = 1'b1;
            end
            OP_ADDI, OP_ADDIU: begin
                cls       = CLS_IALU;
                alu_src_b = 1'b1;
            end
            OP_LW: begin
                cls       = CLS_LW;
                alu_src_b = 1'b1;
            end
            OP_SW: begin
                cls       = CLS_SW;
                alu_src_b = 1'b1;
            end
            OP_BEQ: begin
                cls    = CLS_BEQ;
                alu_op = ALU_SUB;
            end
            OP_J:    cls = CLS_J;
            OP_JAL:  cls = CLS_JAL;
            default: cls = CLS_ILLEGAL;
        endcase

        illegal = (cls == CLS_ILLEGAL);
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (IF/ID/EXE/MEM/WB) driving all datapath strobes.
// Optional MC_CTRL_MEM_WAIT_EN: IF and MEM stall until mem_rdy is high.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_rdy,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic       mem_wr,
    output logic [1:0] ext_op,
    output logic [2:0] alu_op,
    output logic       alu_src_b,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic [1:0] npc_op,
    output logic       illegal,
    output logic [2:0] state
);

    instr_class_t dec_cls;
    logic [1:0]   dec_ext_op;
    logic [2:0]   dec_alu_op;
    logic         dec_alu_src_b;
    logic         dec_illegal;
    logic [2:0]   state_next;
    logic         mem_ok;

`ifdef MC_CTRL_MEM_WAIT_EN
    assign mem_ok = mem_rdy;
`else
    // Memory always completes in one cycle; the handshake input is not needed.
    logic mem_rdy_unused;
    assign mem_rdy_unused = mem_rdy;
    assign mem_ok         = 1'b1;
`endif

    mc_decode u_decode (
        .opcode    (opcode),
        .funct     (funct),
        .cls       (dec_cls),
        .ext_op    (dec_ext_op),
        .alu_op    (dec_alu_op),
        .alu_src_b (dec_alu_src_b),
        .illegal   (dec_illegal)
    );

    // NOTE: state is sequential, so it is updated with non-blocking
    // assignments; the combinational block below uses blocking ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IF;
        else        state <= state_next;
    end

    always_comb begin
        state_next = ST_IF;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        mem_wr     = 1'b0;
        illegal    = 1'b0;
        ext_op     = dec_ext_op;
        alu_op     = ALU_ADD;
        alu_src_b  = 1'b0;
        reg_dst    = RDST_RT;
        wd_sel     = WD_ALU;
        npc_op     = NPC_PC4;

        case (state)
            ST_IF: begin
                ir_wr      = mem_ok;
                pc_wr      = mem_ok;
                state_next = mem_ok ? ST_ID : ST_IF;
            end
            ST_ID: begin
                case (dec_cls)
                    CLS_J: begin
                        pc_wr  = 1'b1;
                        npc_op = NPC_JUMP;
                    end
                    CLS_JAL: begin
                        pc_wr   = 1'b1;
                        npc_op  = NPC_JUMP;
                        reg_wr  = 1'b1;
                        reg_dst = RDST_RA;
                        wd_sel  = WD_PC4;
                    end
                    CLS_JR: begin
                        pc_wr  = 1'b1;
                        npc_op = NPC_RS;
                    end
                    CLS_ILLEGAL: illegal = dec_illegal;
                    default:     state_next = ST_EXE;
                endcase
            end
            ST_EXE: begin
                alu_op    = dec_alu_op;
                alu_src_b = dec_alu_src_b;
                case (dec_cls)
                    CLS_BEQ: begin
                        // Not-taken branch leaves the PC+4 loaded during IF
                        pc_wr  = zero;
                        npc_op = NPC_BRANCH;
                    end
                    CLS_LW, CLS_SW: state_next = ST_MEM;
                    default:        state_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                alu_op    = dec_alu_op;
                alu_src_b = dec_alu_src_b;
                mem_wr    = (dec_cls == CLS_SW) && mem_ok;
                if (!mem_ok)                state_next = ST_MEM;
                else if (dec_cls == CLS_LW) state_next = ST_WB;
                else                        state_next = ST_IF;
            end
            ST_WB: begin
                alu_op    = dec_alu_op;
                alu_src_b = dec_alu_src_b;
                reg_wr    = 1'b1;
                case (dec_cls)
                    CLS_LW: begin
                        wd_sel  = WD_MEM;
                        reg_dst = RDST_RT;
                    end
                    CLS_RALU: reg_dst = RDST_RD;
                    default:  reg_dst = RDST_RT;
                endcase
            end
            default: state_next = ST_IF;
        endcase

        // During reset the register already reads IF, but no write may escape
        if (!rst_n) begin
            pc_wr     = 1'b0;
            ir_wr     = 1'b0;
            reg_wr    = 1'b0;
            mem_wr    = 1'b0;
            illegal   = 1'b0;
            ext_op    = EXT_SIGN;
            alu_op    = ALU_ADD;
            alu_src_b = 1'b0;
            reg_dst   = RDST_RT;
            wd_sel    = WD_ALU;
            npc_op    = NPC_PC4;
        end
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle MIPS control unit. Sequences the shared datapath (register file, immediate extender, ALU, memory port, PC/IR registers) through fetch/decode/execute/memory/writeback states. Generates every datapath strobe and mux select, including the 2-bit extender mode. Sits between the instruction register fields and the multi-cycle datapath top level.

## Interface
Parameters:
- none; all encodings come from the shared package.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]; stable from ID until the next IF completes.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, valid in EXE.
- `mem_rdy` in 1: memory handshake ready; used only with MC_CTRL_MEM_WAIT_EN.
- `pc_wr` out 1: PC load strobe.
- `ir_wr` out 1: IR load strobe.
- `reg_wr` out 1: register file write strobe.
- `mem_wr` out 1: data memory write strobe.
- `ext_op` out 2: extender mode. 00 zero, 01 sign, 10 upper (imm<<16).
- `alu_op` out 3: 000 ADD, 001 SUB, 010 OR, 011 SLT, 100 PASS_B.
- `alu_src_b` out 1: 0 rt data, 1 extender output.
- `reg_dst` out 2: 00 rt, 01 rd, 10 $31.
- `wd_sel` out 2: 00 ALU result, 01 memory data, 10 PC+4.
- `npc_op` out 2: 00 PC+4, 01 branch target, 10 jump target, 11 rs register.
- `illegal` out 1: one-cycle pulse on an undecodable instruction.
- `state` out 3: current state, for debug.

## Operation
- Supported instructions: addu, subu, slt, jr (R-type); ori, lui, addi, addiu, lw, sw, beq, j, jal.
- ext_op mapping:
  - ori → 00.
  - addi/addiu/lw/sw/beq → 01.
  - lui → 10.
  - all others → 01 (don't-care).
- States: IF(0), ID(1), EXE(2), MEM(3), WB(4). Codes 5–7 are unreachable; if entered, next state is IF.
- IF: ir_wr=1, pc_wr=1, npc_op=00 → ID.
- ID:
  - j: pc_wr, npc_op=10 → IF.
  - jal: pc_wr, npc_op=10, reg_wr, reg_dst=10, wd_sel=10 → IF.
  - jr: pc_wr, npc_op=11 → IF.
  - illegal: illegal=1 → IF, with no writes.
  - else → EXE.
- EXE:
  - beq: alu_op=SUB, alu_src_b=0; pc_wr=zero, npc_op=01 → IF.
  - lw/sw: alu_op=ADD, alu_src_b=1 → MEM.
  - others: ALU configured per opcode → WB.
- MEM:
  - sw: mem_wr=1 → IF.
  - lw → WB.
- WB: reg_wr=1.
  - lw: wd_sel=01, reg_dst=00.
  - R-type: reg_dst=01.
  - I-type: reg_dst=00.
  - → IF.
- ALU configuration is held constant from EXE through WB.
- Outputs are combinational from state, opcode and funct. Strobes not listed for a state are 0.

## Timing
- Reset: state=IF.
  - While rst_n=0, all strobes (pc_wr, ir_wr, reg_wr, mem_wr, illegal) are forced to 0.
  - Selects reset to 0, except ext_op=01.
- First IF strobes assert on the first rising edge after rst_n deasserts.
- Latency without waits:
  - beq, j, jal, jr: 2–3 cycles.
  - R-type, I-type ALU ops, sw: 4 cycles.
  - lw: 5 cycles.
- Reset asserted mid-instruction: immediate return to IF. A partially executed instruction performs no further writes.
- beq with zero=0: pc_wr=0 in EXE; the PC already holds PC+4 from IF.

## Configuration
- MC_CTRL_MEM_WAIT_EN defined:
  - IF and MEM hold state until mem_rdy=1.
  - ir_wr, pc_wr (IF) and mem_wr (MEM) are qualified by mem_rdy, so they assert only in the ready cycle.
  - Each stall adds one cycle.
- Undefined: mem_rdy is ignored, and IF and MEM take exactly one cycle.

## Structure
- Package `mc_pkg` holds:
  - State encodings.
  - Opcode and funct constants.
  - EXT_ZERO/EXT_SIGN/EXT_UPPER codes.
  - ALU_*, NPC_*, RDST_*, WD_* codes.
- Sub-module `mc_decode` (combinational): maps opcode/funct to an instruction class, ext_op, alu_op, alu_src_b and illegal.
- `mc_ctrl` holds the state register and the per-state strobe logic.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random opcode → all strobes 0, state=0, ext_op=01.
- ori (opcode 001101): state sequence 0,1,2,4,0 → ext_op=00, alu_op=010, reg_wr=1 only in WB, reg_dst=00.
- lui (001111) then lw (100011):
  - lui → ext_op=10, alu_op=100, 4 cycles.
  - lw → ext_op=01, 5 cycles, wd_sel=01 in WB.
- beq (000100):
  - zero=1 → pc_wr=1, npc_op=01 in EXE.
  - zero=0 → pc_wr=0.
  - Next state IF in both cases.
- jal (000011) → single ID cycle with pc_wr=1, reg_wr=1, reg_dst=10, wd_sel=10. Opcode 111111 → illegal pulse for 1 cycle, no writes.
- With MC_CTRL_MEM_WAIT_EN: sw with mem_rdy low for 2 MEM cycles → state stays 3, mem_wr=0, then mem_wr=1 for exactly one cycle; total 6 cycles.
